// File: rtl/twoscomp_serial.sv
// twoscomp_serial: digit-serial two's-complement pass/negate/abs/nabs unit with valid/ready handshake
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   operand and mode valid
//   o_in_ready   unit can accept an operand (IDLE only)
//   i_in_data    signed operand
//   i_mode       00 pass, 01 negate, 10 abs, 11 nabs
//   o_out_valid  result and flags valid (DONE)
//   i_out_ready  consumer accepts the result
//   o_out_data   result, modulo 2^WIDTH
//   o_ovf        negate/abs of the most-negative value
//   o_zero       result is zero
module twoscomp_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic [1:0]       i_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_ovf,
  output logic             o_zero
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_op, r_res, w_res_next;
  logic [CW-1:0]    r_cnt;
  logic             r_inv, r_carry, r_ovf, r_zero;
  logic [DIGIT-1:0] w_r;
  logic             w_c, w_last, w_inv, w_accept;
  assign w_accept = r_state == IDLE && i_in_valid;
  assign w_last = r_cnt == CW'(N - 1);
  // abs inverts when negative, nabs inverts when non-negative
  assign w_inv = i_mode[1] ? i_in_data[WIDTH-1] ^ i_mode[0] : i_mode[0];
  // conditional one's complement plus carry: adding the initial inv completes the +1 of negation
  assign {w_c, w_r} = {1'b0, r_op[DIGIT-1:0] ^ {DIGIT{r_inv}}} + {{DIGIT{1'b0}}, r_carry};
  // result fills from the top so after N digits the first digit sits at the LSB
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_r) << (WIDTH - DIGIT));
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = RUN;
    else if (r_state == RUN && w_last) w_next = DONE;
    else if (r_state == DONE && i_out_ready) w_next = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_op    <= i_in_data;
      r_inv   <= w_inv;
      r_carry <= w_inv;
      r_cnt   <= '0;
      r_ovf   <= w_inv && i_in_data == MOST_NEG;
    end else if (r_state == RUN) begin
      r_op    <= r_op >> DIGIT;
      r_res   <= w_res_next;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_zero <= w_res_next == '0;
    end
  end
  assign o_in_ready  = r_state == IDLE;
  assign o_out_valid = r_state == DONE;
  assign o_out_data  = r_res;
  assign o_ovf       = r_ovf;
  assign o_zero      = r_zero;
endmodule

// File: tb/tb_twoscomp_serial.sv
// tb_twoscomp_serial: directed-vector check of twoscomp_serial at 32/8, 16/1 and 16/16
module tb_twoscomp_serial;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [1:0]  mode = '0;
  logic        in_ready, out_valid, ovf, zero;
  logic [31:0] out_data;
  logic        v16 = 1'b0;
  logic [15:0] d16 = '0;
  logic [1:0]  m16 = '0;
  logic        rdy_b, val_b, ovf_b, zero_b, rdy_c, val_c, ovf_c, zero_c;
  logic [15:0] out_b, out_c;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  twoscomp_serial #(.WIDTH(32), .DIGIT(8)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_mode(mode), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_ovf(ovf), .o_zero(zero));
  twoscomp_serial #(.WIDTH(16), .DIGIT(1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v16), .o_in_ready(rdy_b),
    .i_in_data(d16), .i_mode(m16), .o_out_valid(val_b), .i_out_ready(1'b1),
    .o_out_data(out_b), .o_ovf(ovf_b), .o_zero(zero_b));
  twoscomp_serial #(.WIDTH(16), .DIGIT(16)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(v16), .o_in_ready(rdy_c),
    .i_in_data(d16), .i_mode(m16), .o_out_valid(val_c), .i_out_ready(1'b1),
    .o_out_data(out_c), .o_ovf(ovf_c), .o_zero(zero_c));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] d, input logic [1:0] m);
    @(negedge clk);
    chk("in_ready_before", in_ready, 1);
    in_valid = 1'b1;
    in_data = d;
    mode = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 0, 1);
  endtask
  task automatic run_op(input string tag, input logic [31:0] d, input logic [1:0] m,
                        input logic [31:0] exp, input logic exp_ovf, input logic exp_zero);
    int lat;
    issue(d, m);
    wait_done(tag, lat);
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_zero"}, zero, exp_zero);
    @(posedge clk);
    #1 chk({tag, "_ready_after"}, in_ready, 1);
  endtask
  initial begin
    int lat, lb, lc;
    logic [15:0] rb, rc;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op("neg5", 32'h0000_0005, 2'b01, 32'hFFFF_FFFB, 0, 0);
    run_op("neg0", 32'h0000_0000, 2'b01, 32'h0000_0000, 0, 1);
    run_op("neg100", 32'h0000_0100, 2'b01, 32'hFFFF_FF00, 0, 0);
    run_op("abs_min", 32'h8000_0000, 2'b10, 32'h8000_0000, 1, 0);
    run_op("nabs_min", 32'h8000_0000, 2'b11, 32'h8000_0000, 0, 0);
    run_op("neg_min", 32'h8000_0000, 2'b01, 32'h8000_0000, 1, 0);
    run_op("pass_min", 32'h8000_0000, 2'b00, 32'h8000_0000, 0, 0);
    run_op("nabs7", 32'h0000_0007, 2'b11, 32'hFFFF_FFF9, 0, 0);
    run_op("absm7", 32'hFFFF_FFF9, 2'b10, 32'h0000_0007, 0, 0);
    run_op("abs7", 32'h0000_0007, 2'b10, 32'h0000_0007, 0, 0);
    run_op("nabsm7", 32'hFFFF_FFF9, 2'b11, 32'hFFFF_FFF9, 0, 0);
    out_ready = 1'b0;
    issue(32'h1234_5678, 2'b00);
    wait_done("bp", lat);
    chk("bp_lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 32'hA5A5_0000 ^ i;
      mode = 2'b01;
      @(posedge clk);
      #1 chk("bp_hold_data", out_data, 32'h1234_5678);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_ready_after", in_ready, 1);
    chk("bp_valid_after", out_valid, 0);
    issue(32'h0000_0005, 2'b01);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("mid_in_ready", in_ready, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_ovf", ovf, 0);
    chk("mid_zero", zero, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op("neg1", 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 0, 0);
    @(negedge clk);
    v16 = 1'b1;
    d16 = 16'h0003;
    m16 = 2'b01;
    @(posedge clk);
    #1 v16 = 1'b0;
    lb = -1;
    lc = -1;
    for (int t = 1; t <= 40 && lb < 0; t++) begin
      @(posedge clk);
      #1;
      if (val_c && lc < 0) begin lc = t; rc = out_c; end
      if (val_b && lb < 0) begin lb = t; rb = out_b; end
    end
    chk("w16d1_lat", lb, 16);
    chk("w16d1_data", rb, 16'hFFFD);
    chk("w16d16_lat", lc, 1);
    chk("w16d16_data", rc, 16'hFFFD);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/twoscomp_serial.md
# twoscomp_serial

Parametrised, multi-cycle two's-complement unit that succeeds the single-cycle 32-bit negator in the datapath. It accepts one WIDTH-bit operand per transaction over a valid/ready handshake and computes one of four sign operations: pass, negate, absolute value or negative absolute value. It processes DIGIT bits per clock, LSB first, with the carry held in a register, so large widths close timing without a full-width adder. It reports overflow and zero flags and sits between the register file read path and the ALU operand mux.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- DIGIT, 8, bits processed per cycle; WIDTH % DIGIT must be 0; DIGIT == WIDTH gives a single RUN cycle.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand and mode are valid.
- in_ready  output  1  unit can accept an operand; high only in IDLE.
- in_data  input  WIDTH  operand, signed two's complement.
- mode  input  2  00 pass, 01 negate, 10 abs, 11 nabs (−|x|).
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- ovf  output  1  result is not representable; asserted only for negate or abs of the most-negative value.
- zero  output  1  out_data == 0.

## Operation
- States: IDLE, RUN, DONE. Let N = WIDTH/DIGIT.
- IDLE: in_ready=1. When in_valid=1, capture in_data into the operand shift register and go to RUN.
  - At capture, set the invert flag inv: pass→0, negate→1, abs→in_data[WIDTH-1], nabs→~in_data[WIDTH-1].
  - At capture, set the carry register to inv and the digit counter to 0.
- RUN, each cycle:
  - Take the low DIGIT bits d and compute {c, r} = (d ^ {DIGIT{inv}}) + carry, DIGIT+1 bits wide.
  - Shift r into the top of the result register, LSB-first accumulation.
  - Shift the operand right by DIGIT, set carry ← c, and increment the counter.
  - After the N-th digit, go to DONE.
- Final carry-out is discarded; result is modulo 2^WIDTH.
- ovf = inv & (operand == 1 followed by WIDTH-1 zeros).
  - Evaluate it at capture and register it.
  - nabs never overflows; pass never overflows.
- zero is computed from the final result and registered on the RUN→DONE transition.
- DONE: out_valid=1. out_data, ovf and zero stay stable until out_ready=1, then go to IDLE.
- Inputs are ignored outside IDLE; in_data and mode changes during RUN or DONE have no effect.
- Reset, at any time including mid-RUN or in DONE: go to IDLE immediately and abandon any in-flight operation.
  - Reset values: in_ready=1, out_valid=0, out_data=0, ovf=0, zero=0; internal carry, counter and shift registers = 0.

## Timing
- Acceptance edge: the rising edge with in_valid & in_ready. N RUN cycles follow.
- out_valid rises N cycles after the acceptance edge (N=4 at default parameters).
- Output handshake: the transaction completes on the edge with out_valid & out_ready. in_ready goes high on the following cycle, with no same-cycle bypass.
- Maximum throughput: one operation per N+2 cycles when out_ready is held at 1.
- out_valid, out_data, ovf and zero are register outputs with no combinational path from inputs.
- in_ready is a decode of state only; it does not depend on out_ready.
- The critical path is one DIGIT-bit adder plus the carry register, independent of WIDTH.

## Test plan
- Negate, W=32, D=8: in_data=0x00000005, mode=01 → out_data=0xFFFFFFFB, ovf=0, zero=0; out_valid high exactly 4 cycles after acceptance.
- Full-length carry ripple: mode=01, in_data=0x00000000 → out_data=0x00000000, zero=1, ovf=0. Also in_data=0x00000100 → 0xFFFFFF00, which exercises carry across digit boundaries.
- Overflow cases:
  - abs of 0x80000000 → out_data=0x80000000, ovf=1.
  - nabs of 0x80000000 → 0x80000000, ovf=0.
  - nabs of 0x00000007 → 0xFFFFFFF9.
  - abs of 0xFFFFFFF9 → 0x00000007.
- Backpressure: pass of 0x12345678 with out_ready=0 for 5 cycles after out_valid rises → out_data held at 0x12345678 and in_ready=0 throughout. in_data toggled during this time does not affect the result. After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst_n=0 asynchronously in the 2nd RUN cycle → all outputs take their reset values without waiting for a clock edge. After release, a fresh negate of 1 → 0xFFFFFFFF with normal latency.
- Alternate configurations:
  - W=16, D=1: negate 0x0003 → 0xFFFD after 16 cycles.
  - W=16, D=16: the same negate completes after 1 cycle.
